alu_cmd_sequencer: RTL and testbench

- Front-end stage of the ALU. Accepts one operation at a time through a valid/ready command port, registers the operands and decodes the opcode.
- Issues a one-cycle enable pulse to exactly one execution unit: arith, logic, compare or shift. Each unit registers its OUT and Flag one cycle after its enable.
- Waits for the selected unit's Flag, captures the result, and returns it on a valid/ready response port.
- Includes a timeout, so a missing Flag can never hang the ALU.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_result_mux.sv | 45 ++++
 rtl/alu_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU front-end: unit-select codes,
// sequencer FSM encoding and the default operand width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [1:0] U_ARITH = 2'b00;
    localparam logic [1:0] U_LOGIC = 2'b01;
    localparam logic [1:0] U_CMP   = 2'b10;
    localparam logic [1:0] U_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_result_mux.sv
// Selects the result and completion flag of the addressed execution unit,
// zero-extending the single-width units to the full response width.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int width = ALU_WIDTH
) (
    input  logic [1:0]         usel,
    input  logic [2*width-1:0] Arith_OUT,
    input  logic               Arith_Flag,
    input  logic [width-1:0]   Logic_OUT,
    input  logic               Logic_Flag,
    input  logic [width-1:0]   CMP_OUT,
    input  logic               CMP_Flag,
    input  logic [width-1:0]   Shift_OUT,
    input  logic               Shift_Flag,
    output logic [2*width-1:0] sel_out,
    output logic               sel_flag
);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        sel_out  = '0;
        sel_flag = 1'b0;
        case (usel)
            U_ARITH: begin
                sel_out  = Arith_OUT;
                sel_flag = Arith_Flag;
            end
            U_LOGIC: begin
                sel_out  = {{width{1'b0}}, Logic_OUT};
                sel_flag = Logic_Flag;
            end
            U_CMP: begin
                sel_out  = {{width{1'b0}}, CMP_OUT};
                sel_flag = CMP_Flag;
            end
            default: begin
                sel_out  = {{width{1'b0}}, Shift_OUT};
                sel_flag = Shift_Flag;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU front-end: accepts one command, pulses the selected unit's enable,
// waits (bounded by TIMEOUT) for its flag and returns the result.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int width   = ALU_WIDTH,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_fun,
    input  logic [width-1:0]   op_a,
    input  logic [width-1:0]   op_b,
    output logic [width-1:0]   A,
    output logic [width-1:0]   B,
    output logic [1:0]         ALU_FUN,
    output logic               Arith_Enable,
    output logic               Logic_Enable,
    output logic               CMP_Enable,
    output logic               Shift_Enable,
    input  logic [2*width-1:0] Arith_OUT,
    input  logic               Arith_Flag,
    input  logic [width-1:0]   Logic_OUT,
    input  logic               Logic_Flag,
    input  logic [width-1:0]   CMP_OUT,
    input  logic               CMP_Flag,
    input  logic [width-1:0]   Shift_OUT,
    input  logic               Shift_Flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*width-1:0] rsp_data,
    output logic               rsp_err
);

    seq_state_t         state_q, state_d;
    logic [1:0]         usel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;
    logic [2*width-1:0] sel_out;
    logic               sel_flag;

    alu_result_mux #(.width(width)) u_mux (
        .usel       (usel_q),
        .Arith_OUT  (Arith_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .Shift_OUT  (Shift_OUT),
        .Shift_Flag (Shift_Flag),
        .sel_out    (sel_out),
        .sel_flag   (sel_flag)
    );

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sel_flag || timeout_hit) state_d = RESP;
            default: if (rsp_ready) state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from registers only, so no input reaches an output combinationally.
    always_comb begin
        cmd_ready    = (state_q == IDLE);
        rsp_valid    = (state_q == RESP);
        Arith_Enable = 1'b0;
        Logic_Enable = 1'b0;
        CMP_Enable   = 1'b0;
        Shift_Enable = 1'b0;
        if (state_q == ISSUE) begin
            Arith_Enable = (usel_q == U_ARITH);
            Logic_Enable = (usel_q == U_LOGIC);
            CMP_Enable   = (usel_q == U_CMP);
            Shift_Enable = (usel_q == U_SHIFT);
        end
    end

    // Operands are only written on acceptance, keeping unit inputs stable while busy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            A        <= '0;
            B        <= '0;
            ALU_FUN  <= '0;
            usel_q   <= U_ARITH;
            cnt_q    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        A       <= op_a;
                        B       <= op_b;
                        ALU_FUN <= cmd_fun[1:0];
                        usel_q  <= cmd_fun[3:2];
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    if (sel_flag) begin
                        rsp_data <= sel_out;
                        rsp_err  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with behavioural execution units,
// directed timing/corner cases and a randomized command stream.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W   = 16;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_fun = '0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic [W-1:0]  A, B;
    logic [1:0]    ALU_FUN;
    logic          Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [2*W-1:0] Arith_OUT;
    logic          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic [W-1:0]  Logic_OUT, CMP_OUT, Shift_OUT;
    logic          rsp_valid;
    wire           rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic          rsp_err;

    logic          rand_ready = 1'b0, ready_manual = 1'b0, rnd_bit = 1'b0;
    logic          shift_stuck = 1'b0, spur_cmp = 1'b0;
    logic [2*W-1:0] arith_q;
    logic [W-1:0]  logic_q, cmp_q, shift_q;
    logic          arith_f, logic_f, cmp_f, shift_f;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] sb[$];

    assign rsp_ready  = rand_ready ? rnd_bit : ready_manual;
    assign Arith_OUT  = arith_q;
    assign Arith_Flag = arith_f;
    assign Logic_OUT  = logic_q;
    assign Logic_Flag = logic_f;
    assign CMP_OUT    = spur_cmp ? 16'hFFFF : cmp_q;
    assign CMP_Flag   = cmp_f | spur_cmp;
    assign Shift_OUT  = shift_q;
    assign Shift_Flag = shift_f;

    alu_cmd_sequencer #(.width(W), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fun(cmd_fun), .op_a(op_a), .op_b(op_b), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;

    // Unit behaviour: arith add/sub/mul/div, logic and/or/xor/nand,
    // compare none/eq->1/gt->2/lt->3, shift a>>1/a<<1/b>>1/b<<1.
    function automatic logic [2*W-1:0] f_arith(input logic [1:0] f, input logic [W-1:0] a, b);
        logic [2*W-1:0] xa, xb;
        xa = {{W{1'b0}}, a};
        xb = {{W{1'b0}}, b};
        case (f)
            2'd0: return xa + xb;
            2'd1: return xa - xb;
            2'd2: return xa * xb;
            default: return (b == 0) ? '0 : xa / xb;
        endcase
    endfunction

    function automatic logic [W-1:0] f_logic(input logic [1:0] f, input logic [W-1:0] a, b);
        case (f)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [W-1:0] f_cmp(input logic [1:0] f, input logic [W-1:0] a, b);
        case (f)
            2'd1: return (a == b) ? W'(1) : '0;
            2'd2: return (a > b)  ? W'(2) : '0;
            2'd3: return (a < b)  ? W'(3) : '0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] f_shift(input logic [1:0] f, input logic [W-1:0] a, b);
        case (f)
            2'd0: return a >> 1;
            2'd1: return a << 1;
            2'd2: return b >> 1;
            default: return b << 1;
        endcase
    endfunction

    // Expected {rsp_err, rsp_data} for a command, straight from the operands.
    function automatic logic [32:0] model(input logic [3:0] fun, input logic [W-1:0] a, b);
        case (fun[3:2])
            2'b00: return {1'b0, f_arith(fun[1:0], a, b)};
            2'b01: return {1'b0, 16'h0, f_logic(fun[1:0], a, b)};
            2'b10: return {1'b0, 16'h0, f_cmp(fun[1:0], a, b)};
            default: return shift_stuck ? {1'b1, 32'h0} : {1'b0, 16'h0, f_shift(fun[1:0], a, b)};
        endcase
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            arith_f <= 1'b0; logic_f <= 1'b0; cmp_f <= 1'b0; shift_f <= 1'b0;
            arith_q <= '0; logic_q <= '0; cmp_q <= '0; shift_q <= '0;
        end else begin
            arith_f <= Arith_Enable;
            logic_f <= Logic_Enable;
            cmp_f   <= CMP_Enable;
            shift_f <= Shift_Enable & ~shift_stuck;
            arith_q <= f_arith(ALU_FUN, A, B);
            logic_q <= f_logic(ALU_FUN, A, B);
            cmp_q   <= f_cmp(ALU_FUN, A, B);
            shift_q <= f_shift(ALU_FUN, A, B);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Monitor: every response that is about to handshake is popped and compared.
    initial forever begin
        @(negedge CLK);
        if (RST && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) check("unexpected_rsp", 64'(rsp_data), 64'hDEAD);
            else check("rsp", 64'({rsp_err, rsp_data}), 64'(sb.pop_front()));
        end
    end

    task automatic send(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_fun = fun; op_a = a; op_b = b;
        @(posedge CLK);
        sb.push_back(model(fun, a, b));
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 300) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= 300) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    logic [2*W-1:0] held;
    int cyc;

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_outputs", 64'({rsp_valid, rsp_err, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}), 64'd0);
        check("rst_regs", 64'({A, B, ALU_FUN, rsp_data}), 64'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Compare-greater timing, then backpressure with a stray command.
        send(4'b1010, 16'd5, 16'd3);
        check("issue_enables", 64'({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}), 64'b0010);
        check("issue_busy", 64'(cmd_ready), 64'd0);
        @(posedge CLK); #1;
        check("enable_drop", 64'({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}), 64'd0);
        check("no_rsp_k1", 64'(rsp_valid), 64'd0);
        @(posedge CLK); #1;
        check("rsp_valid_k2", 64'(rsp_valid), 64'd1);
        check("rsp_data_k2", 64'({rsp_err, rsp_data}), 64'd2);
        held = rsp_data;
        cmd_valid = 1'b1; cmd_fun = 4'b0001; op_a = 16'h1234; op_b = 16'h4321;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("bp_hold", 64'({rsp_valid, cmd_ready, rsp_data}), 64'({1'b1, 1'b0, held}));
            check("bp_operands", 64'({A, B, ALU_FUN}), 64'({16'd5, 16'd3, 2'b10}));
        end
        cmd_valid = 1'b0;
        ready_manual = 1'b1;
        @(posedge CLK); #1;
        check("ready_after_hs", 64'({cmd_ready, rsp_valid}), 64'b10);

        // Wide multiply result must not be truncated.
        send(4'b0010, 16'd300, 16'd300);
        drain();

        // Stuck shift flag: error response after TMO wait cycles, then recovery.
        shift_stuck = 1'b1;
        send(4'b1100, 16'h00F0, 16'h0003);
        cyc = 0;
        do begin
            @(posedge CLK); #1; cyc++;
        end while (!rsp_valid && cyc < 50);
        check("timeout_latency", 64'(cyc), 64'(TMO + 1));
        check("timeout_rsp", 64'({rsp_err, rsp_data}), 64'({1'b1, 32'h0}));
        drain();
        shift_stuck = 1'b0;
        send(4'b1101, 16'h00F0, 16'h0003);
        drain();

        // Spurious compare flag during a logic command is ignored.
        send(4'b0110, 16'hA5A5, 16'h0FF0);
        spur_cmp = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        spur_cmp = 1'b0;
        drain();

        // Asynchronous reset in the middle of WAIT.
        shift_stuck = 1'b1;
        send(4'b1110, 16'h1111, 16'h2222);
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b0;
        #1;
        check("midrst_outputs", 64'({cmd_ready, rsp_valid, rsp_err, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}), 64'b1000000);
        check("midrst_regs", 64'({A, B, rsp_data}), 64'd0);
        sb.delete();
        shift_stuck = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        check("post_rst_ready", 64'(cmd_ready), 64'd1);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (rsp_valid) cyc++;
        end
        check("no_stale_rsp", 64'(cyc), 64'd0);
        send(4'b0000, 16'hFFFF, 16'h0001);
        drain();

        // Random commands with random response backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++)
            send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        drain();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
